inst_fetch_queue: RTL

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_pkg.sv | 22 ++
 rtl/inst_fetch_queue_fifo.sv | 65 ++++++
 rtl/inst_fetch_queue.sv | 105 ++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared CPU constants and the types used by the instruction-fetch front end.
package inst_fetch_queue_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Prefetch queue storage: circular buffer of {pc, inst} entries with flush.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  fetch_entry_t     entry_mem [DEPTH];

  // Pointer and occupancy next-state; a pop frees the slot a same-cycle push uses when full.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) entry_mem[wr_ptr_q] <= entry_i;
  end

  assign head_o  = entry_mem[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues word requests, tracks in-flight responses,
// discards stale responses after a redirect and buffers instructions for ID.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              imem_req_o,
  output logic [31:0]       imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [31:0]       pc_o,
  input  logic              inst_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   in_flight;
  logic             running, grant, rsp_any, rsp_drop, push, pop, flush;
  fetch_entry_t     head, push_entry;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (occupancy)
  );

  // Request/consume handshakes and output muxing; an empty queue presents a NOP.
  always_comb begin
    running      = (state_q == ST_RUN);
    in_flight    = {1'b0, occupancy} + {1'b0, outstanding_q};
    imem_req_o   = running && !redirect_i && (in_flight < (CNT_W+1)'(DEPTH));
    imem_addr_o  = fetch_pc_q;
    grant        = imem_req_o && imem_gnt_i;
    inst_valid_o = running && (occupancy != '0) && !redirect_i;
    pop          = inst_valid_o && inst_ready_i;
    inst_o       = (occupancy != '0) ? head.inst : NOP_INST;
    pc_o         = (occupancy != '0) ? head.pc : resp_pc_q;
    // Pulses with nothing in flight belong to requests abandoned by reset.
    rsp_any      = imem_rvalid_i && (outstanding_q != '0);
    rsp_drop     = rsp_any && (discard_q != '0);
    push         = rsp_any && !rsp_drop && running && !redirect_i;
    flush        = running && redirect_i;
    push_entry.pc   = resp_pc_q;
    push_entry.inst = imem_rdata_i;
  end

  // Next-state for the FSM, fetch/response PCs and in-flight bookkeeping.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp_any);
    if ((state_q == ST_IDLE) && start_i) state_d = ST_RUN;
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      resp_pc_d  = word_align(redirect_pc_i);
      // Everything still in flight after this edge predates the redirect.
      if (running) discard_d = outstanding_d;
    end else begin
      if (grant)    fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)     resp_pc_d  = resp_pc_q + 32'd4;
      if (rsp_drop) discard_d  = discard_q - 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule
